// File: rtl/pipeline_flow_control.sv
// Branch/jump flow control: stall gating, resolve-delay tracking,
// next-PC select, pipeline flush and a saturating stall-cycle counter.
module pipeline_flow_control #(
   parameter int BRANCH_DELAY      = 2,
   parameter int NUM_STALL         = 2,
   parameter int PREDICT_NOT_TAKEN = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [6:0]           inst_opcode,
   input  logic                 take_branch,
   input  logic [NUM_STALL-1:0] want_stall,
   output logic                 pc_write_enable,
   output logic                 no_stall,
   output logic                 inject_bubble,
   output logic                 flush,
   output logic                 jump_start,
   output logic                 link_write_enable,
   output logic                 branch_busy,
   output logic [1:0]           next_pc_select,
   output logic [31:0]          stall_cycles
);

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] CTL_PC_PC4     = 2'd0;
   localparam logic [1:0] CTL_PC_PC_IMM  = 2'd1;
   localparam logic [1:0] CTL_PC_RS1_IMM = 2'd2;
   localparam logic [1:0] CTL_PC_PC4_BR  = 2'd3;

   localparam logic [2:0] LP_CNT_INIT =
      3'(BRANCH_DELAY >= 2 ? BRANCH_DELAY - 2 : 0);
   localparam logic LP_PREDICT = (PREDICT_NOT_TAKEN != 0);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RESOLVE = 2'd2
   } state_t;

   state_t      r_state;
   logic [2:0]  r_cnt;
   logic [6:0]  r_held_opcode;
   logic [31:0] r_stall_cycles;

   logic w_any_stall;
   logic w_is_link;
   logic w_is_jump;
   logic w_redirect;

   assign w_any_stall = |want_stall;
   assign w_is_link   = (inst_opcode == OP_JAL) || (inst_opcode == OP_JALR);
   assign w_is_jump   = w_is_link || (inst_opcode == OP_BRANCH);
   assign w_redirect  = (r_held_opcode != OP_BRANCH) || take_branch;

   assign branch_busy  = (r_state != S_IDLE);
   assign stall_cycles = r_stall_cycles;

   always_comb begin
      pc_write_enable   = 1'b0;
      no_stall          = 1'b0;
      inject_bubble     = 1'b0;
      flush             = 1'b0;
      jump_start        = 1'b0;
      link_write_enable = 1'b0;
      next_pc_select    = CTL_PC_PC4;
      if (reset) begin
         inject_bubble = 1'b1;
         flush         = 1'b1;
      end else if (w_any_stall) begin
         inject_bubble = 1'b1;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_is_jump) begin
                  jump_start        = 1'b1;
                  link_write_enable = w_is_link;
                  pc_write_enable   = LP_PREDICT;
                  no_stall          = LP_PREDICT;
               end else begin
                  pc_write_enable = 1'b1;
                  no_stall        = 1'b1;
               end
            end
            S_WAIT: begin
               pc_write_enable = LP_PREDICT;
               no_stall        = LP_PREDICT;
            end
            S_RESOLVE: begin
               pc_write_enable = 1'b1;
               no_stall        = 1'b1;
               flush           = LP_PREDICT && w_redirect;
               if (r_held_opcode == OP_JALR)
                  next_pc_select = CTL_PC_RS1_IMM;
               else if (w_redirect)
                  next_pc_select = CTL_PC_PC_IMM;
               else if (!LP_PREDICT)
                  next_pc_select = CTL_PC_PC4_BR;
            end
            default: begin
               pc_write_enable = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_cnt          <= 3'd0;
         r_held_opcode  <= 7'd0;
         r_stall_cycles <= 32'd0;
      end else begin
         if (!pc_write_enable && (r_stall_cycles != 32'hFFFF_FFFF))
            r_stall_cycles <= r_stall_cycles + 32'd1;
         // A stall freezes the whole control state, including a pending resolve
         if (!w_any_stall) begin
            unique case (r_state)
               S_IDLE: begin
                  if (w_is_jump) begin
                     r_held_opcode <= inst_opcode;
                     r_cnt         <= LP_CNT_INIT;
                     r_state       <= (BRANCH_DELAY == 1) ? S_RESOLVE : S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (r_cnt == 3'd0)
                     r_state <= S_RESOLVE;
                  else
                     r_cnt <= r_cnt - 3'd1;
               end
               S_RESOLVE: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
